// File: rtl/carp_fetch_pkg.sv
// Shared types and constants for the CARP fetch front end.
package carp_fetch_pkg;

   localparam int unsigned INSTR_BYTES = 4;
   // Reserved for filling flushed slots with a harmless addi x0,x0,0.
   localparam logic [31:0] NOP_IR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] nextpc;
      logic [31:0] ir;
   } fq_entry_t;

   localparam int unsigned ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry array: one synchronous write port, one asynchronous read port, no reset.
module fq_storage
   import carp_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = $clog2(DEPTH)
) (
   input  logic               CLK,
   input  logic               we_i,
   input  logic [PW-1:0]      waddr_i,
   input  logic [ENTRY_W-1:0] wdata_i,
   input  logic [PW-1:0]      raddr_i,
   output logic [ENTRY_W-1:0] rdata_o
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   always_ff @(posedge CLK) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// CARP instruction-fetch front end: owns fetch PC, drives IMEM, buffers fetched words for decode.
// Define FQ_BYPASS_EN to let an empty queue forward the IMEM word straight to decode.
module fetch_queue
   import carp_fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     REDIRECT,
   input  logic [31:0]              REDIRECT_PC,
   output logic                     IMEM_RDEN,
   output logic [13:0]              IMEM_ADDR,
   input  logic [31:0]              IMEM_DATA,
   output logic                     D_VALID,
   input  logic                     D_READY,
   output logic [31:0]              D_PC,
   output logic [31:0]              D_NEXTPC,
   output logic [31:0]              D_IR,
   output logic [$clog2(DEPTH):0]   COUNT
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   fetch_pc_q;

   logic          empty, full, bypass, pop, push, fifo_pop, fifo_push;
   fq_entry_t     fetch_entry, head_entry, out_entry;
   logic          unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   assign fetch_entry = '{pc:     fetch_pc_q,
                          nextpc: fetch_pc_q + 32'(INSTR_BYTES),
                          ir:     IMEM_DATA};

`ifdef FQ_BYPASS_EN
   assign bypass = empty & ~REDIRECT;
`else
   assign bypass = 1'b0;
`endif

   fq_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .CLK     (CLK),
      .we_i    (fifo_push),
      .waddr_i (wr_ptr_q),
      .wdata_i (fetch_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_entry)
   );

   always_comb begin
      D_VALID   = ~REDIRECT & (~empty | bypass);
      pop       = D_VALID & D_READY;
      push      = ~REDIRECT & (~full | pop);
      fifo_pop  = pop & ~empty;
      // A bypassed word consumed by decode never occupies a slot.
      fifo_push = push & ~(bypass & D_READY);

      count_d = count_q;
      case ({fifo_push, fifo_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (!empty) begin
         out_entry = head_entry;
      end else if (bypass) begin
         out_entry = fetch_entry;
      end else begin
         out_entry = '0;
      end
   end

   assign IMEM_RDEN = push;
   assign IMEM_ADDR = fetch_pc_q[15:2];
   assign D_PC      = out_entry.pc;
   assign D_NEXTPC  = out_entry.nextpc;
   assign D_IR      = out_entry.ir;
   assign COUNT     = count_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         fetch_pc_q <= RESET_PC;
      end else if (REDIRECT) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         fetch_pc_q <= {REDIRECT_PC[31:2], 2'b00};
      end else begin
         if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (push) fetch_pc_q <= fetch_pc_q + 32'(INSTR_BYTES);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences, random vs queue model.
module tb_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        red = 1'b0;
   logic [31:0] rpc = '0;
   logic        rdy = 1'b0;
   logic        imem_rden;
   logic [13:0] imem_addr;
   logic [31:0] imem_data;
   logic        d_valid;
   logic [31:0] d_pc, d_nextpc, d_ir;
   logic [$clog2(DEPTH):0] count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [13:0] a);
      return {2'b10, a, 2'b01, ~a};
   endfunction

   assign imem_data = imem_word(imem_addr);

   fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .REDIRECT    (red),
      .REDIRECT_PC (rpc),
      .IMEM_RDEN   (imem_rden),
      .IMEM_ADDR   (imem_addr),
      .IMEM_DATA   (imem_data),
      .D_VALID     (d_valid),
      .D_READY     (rdy),
      .D_PC        (d_pc),
      .D_NEXTPC    (d_nextpc),
      .D_IR        (d_ir),
      .COUNT       (count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of fetched PCs plus the next PC to fetch.
   logic [31:0] mq[$];
   logic [31:0] m_fpc = '0;
   bit          m_known = 1'b0;
   bit          e_byp, e_valid, e_pop, e_push;
   logic [31:0] e_head;

   task automatic model_check();
      e_byp   = BYP && mq.size() == 0 && !red;
      e_valid = !red && (mq.size() != 0 || e_byp);
      e_head  = (mq.size() != 0) ? mq[0] : m_fpc;
      e_pop   = e_valid && rdy;
      e_push  = !red && (mq.size() < DEPTH || e_pop);
      if (m_known) begin
         chk("m_valid", 32'(d_valid), 32'(e_valid));
         chk("m_rden", 32'(imem_rden), 32'(e_push));
         chk("m_count", 32'(count), mq.size());
         chk("m_addr", 32'(imem_addr), 32'(m_fpc[15:2]));
         total++;
         if (count > DEPTH) begin
            bad++;
            $display("FAIL count_bound: got %0d limit %0d", count, DEPTH);
         end
         if (e_valid) begin
            chk("m_pc", d_pc, e_head);
            chk("m_nextpc", d_nextpc, e_head + 32'd4);
            chk("m_ir", d_ir, imem_word(e_head[15:2]));
         end else if (mq.size() == 0) begin
            chk("m_pc_empty", d_pc, 32'h0);
         end
      end
   endtask

   task automatic model_update();
      if (rst) begin
         mq.delete();
         m_fpc   = RESET_PC;
         m_known = 1'b1;
      end else if (red) begin
         mq.delete();
         m_fpc = rpc & ~32'h3;
      end else begin
         if (e_pop && !e_byp) void'(mq.pop_front());
         if (e_push && !(e_byp && e_pop)) mq.push_back(m_fpc);
         if (e_push) m_fpc = m_fpc + 32'd4;
      end
   endtask

   task automatic drive(input bit r, input bit rd, input logic [31:0] p, input bit y);
      @(negedge clk);
      rst = r;
      red = rd;
      rpc = p;
      rdy = y;
      #1;
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
   endtask

   typedef struct {
      bit          r, rd;
      logic [31:0] p;
      bit          y;
      bit          ev;
      logic [31:0] epc;
      int          ecnt;
      bit          erden;
   } vec_t;

   function automatic vec_t mk(bit r, bit rd, logic [31:0] p, bit y,
                               bit ev, logic [31:0] epc, int ecnt, bit erden);
      vec_t v;
      v.r = r; v.rd = rd; v.p = p; v.y = y;
      v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.erden = erden;
      return v;
   endfunction

   vec_t tbl[22];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(0, 0, 32'h0,   1, 0, 32'h0,   0, 1);
      tbl[1]  = mk(0, 0, 32'h0,   1, 1, 32'h0,   1, 1);
      tbl[2]  = mk(0, 0, 32'h0,   1, 1, 32'h4,   1, 1);
      tbl[3]  = mk(0, 0, 32'h0,   0, 1, 32'h8,   1, 1);
      tbl[4]  = mk(0, 0, 32'h0,   0, 1, 32'h8,   2, 1);
      tbl[5]  = mk(0, 0, 32'h0,   0, 1, 32'h8,   3, 1);
      tbl[6]  = mk(0, 0, 32'h0,   0, 1, 32'h8,   4, 0);
      tbl[7]  = mk(0, 0, 32'h0,   0, 1, 32'h8,   4, 0);
      tbl[8]  = mk(0, 0, 32'h0,   1, 1, 32'h8,   4, 1);
      tbl[9]  = mk(0, 0, 32'h0,   1, 1, 32'hC,   4, 1);
      tbl[10] = mk(0, 0, 32'h0,   0, 1, 32'h10,  4, 0);
      tbl[11] = mk(0, 0, 32'h0,   0, 1, 32'h10,  4, 0);
      tbl[12] = mk(0, 1, 32'h203, 1, 0, 32'h0,   4, 0);
      tbl[13] = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1);
      tbl[14] = mk(0, 0, 32'h0,   0, 1, 32'h200, 1, 1);
      tbl[15] = mk(0, 0, 32'h0,   0, 1, 32'h200, 2, 1);
      tbl[16] = mk(0, 1, 32'h403, 1, 0, 32'h0,   3, 0);
      tbl[17] = mk(0, 0, 32'h0,   1, 0, 32'h0,   0, 1);
      tbl[18] = mk(0, 0, 32'h0,   1, 1, 32'h400, 1, 1);
      tbl[19] = mk(1, 1, 32'h800, 0, 0, 32'h0,   1, 0);
      tbl[20] = mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 1);
      tbl[21] = mk(0, 0, 32'h0,   1, 1, 32'h0,   1, 1);

      drive(1, 0, 32'h0, 0);
      tick();

`ifndef FQ_BYPASS_EN
      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].rd, tbl[i].p, tbl[i].y);
         chk($sformatf("t%0d_valid", i), 32'(d_valid), 32'(tbl[i].ev));
         chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
         chk($sformatf("t%0d_rden", i), 32'(imem_rden), 32'(tbl[i].erden));
         if (tbl[i].ev) begin
            chk($sformatf("t%0d_pc", i), d_pc, tbl[i].epc);
            chk($sformatf("t%0d_nextpc", i), d_nextpc, tbl[i].epc + 32'd4);
            chk($sformatf("t%0d_ir", i), d_ir, imem_word(tbl[i].epc[15:2]));
         end
         tick();
      end
`endif

      // Stall from reset: queue saturates with 0x0..0xC, then drains in order.
      drive(1, 0, 32'h0, 0);
      tick();
      for (int c = 0; c < 10; c++) begin
         drive(0, 0, 32'h0, 0);
         tick();
      end
      drive(0, 0, 32'h0, 0);
      chk("stall_count", 32'(count), 32'd4);
      chk("stall_rden", 32'(imem_rden), 32'd0);
      chk("stall_addr", 32'(imem_addr), 32'h4);
      tick();
      for (int c = 0; c < 5; c++) begin
         drive(0, 0, 32'h0, 1);
         chk($sformatf("drain%0d_valid", c), 32'(d_valid), 32'd1);
         chk($sformatf("drain%0d_pc", c), d_pc, 32'(c * 4));
         tick();
      end

      // Fetch PC wraps past the top of the address space.
      drive(0, 1, 32'hFFFF_FFF9, 1);
      tick();
      for (int c = 0; c < 6; c++) begin
         drive(0, 0, 32'h0, (c % 2) == 1);
         tick();
      end

      for (int c = 0; c < 1000; c++) begin
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom,
               $urandom_range(0, 2) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
